// File: rtl/return_addr_stack.sv
// return_addr_stack: circular return-address stack feeding the branch predictor.
// Optional RAS_STATS_EN adds overflow/underflow/pop event counters.
module return_addr_stack #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  CACHE_READY,
    input  logic                  CACHE_READY_DATA,
    input  logic                  FLUSH,
    input  logic                  PUSH,
    input  logic [ADDR_WIDTH-1:0] PUSH_ADDR,
    input  logic                  POP,
    output logic [ADDR_WIDTH-1:0] RETURN_ADDR,
    output logic                  EMPTY,
    output logic                  FULL
`ifdef RAS_STATS_EN
    ,
    output logic [31:0]           OVF_COUNT,
    output logic [31:0]           UNF_COUNT,
    output logic [31:0]           POP_COUNT
`endif
);
    localparam int PTR_WIDTH = $clog2(DEPTH);

    logic [ADDR_WIDTH-1:0] stack [DEPTH];
    logic [PTR_WIDTH-1:0]  tos;
    logic [PTR_WIDTH:0]    count;
    logic                  en;
    logic                  is_empty;
    logic                  is_full;

    assign en       = CACHE_READY & CACHE_READY_DATA & ~FLUSH;
    assign is_empty = count == '0;
    assign is_full  = count == (PTR_WIDTH+1)'(DEPTH);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            tos   <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
`ifdef RAS_STATS_EN
            OVF_COUNT <= '0;
            UNF_COUNT <= '0;
            POP_COUNT <= '0;
`endif
        end else if (en) begin
            // an empty stack treats push+pop as a plain push
            if (PUSH && (!POP || is_empty)) begin
                if (is_empty) begin
                    stack[tos] <= PUSH_ADDR;
                    count      <= (PTR_WIDTH+1)'(1);
                end else begin
                    tos                <= tos + 1'b1;
                    stack[tos + 1'b1]  <= PUSH_ADDR;
                    if (!is_full) count <= count + 1'b1;
                end
            end else if (PUSH && POP) begin
                stack[tos] <= PUSH_ADDR;
            end else if (POP && !is_empty) begin
                tos   <= tos - 1'b1;
                count <= count - 1'b1;
            end
`ifdef RAS_STATS_EN
            if (PUSH && !POP && is_full) OVF_COUNT <= OVF_COUNT + 1'b1;
            if (POP && !PUSH && is_empty) UNF_COUNT <= UNF_COUNT + 1'b1;
            if (POP) POP_COUNT <= POP_COUNT + 1'b1;
`endif
        end
    end

    always_comb begin
        RETURN_ADDR = is_empty ? '0 : stack[tos];
        EMPTY       = is_empty;
        FULL        = is_full;
    end
endmodule

// File: tb/tb_return_addr_stack.sv
// tb_return_addr_stack: scoreboard bench comparing the RAS against a queue model.
// Expectations are queued per issued cycle; a monitor pops and compares after each edge.
module tb_return_addr_stack;
    localparam int AW = 32;
    localparam int D  = 8;

    logic          CLK = 0, RSTN = 0;
    logic          CACHE_READY = 0, CACHE_READY_DATA = 0, FLUSH = 0, PUSH = 0, POP = 0;
    logic [AW-1:0] PUSH_ADDR = '0;
    logic [AW-1:0] RETURN_ADDR;
    logic          EMPTY, FULL;
`ifdef RAS_STATS_EN
    logic [31:0]   OVF_COUNT, UNF_COUNT, POP_COUNT;
`endif

    return_addr_stack #(.ADDR_WIDTH(AW), .DEPTH(D)) dut (
        .CLK(CLK), .RSTN(RSTN), .CACHE_READY(CACHE_READY), .CACHE_READY_DATA(CACHE_READY_DATA),
        .FLUSH(FLUSH), .PUSH(PUSH), .PUSH_ADDR(PUSH_ADDR), .POP(POP),
        .RETURN_ADDR(RETURN_ADDR), .EMPTY(EMPTY), .FULL(FULL)
`ifdef RAS_STATS_EN
        , .OVF_COUNT(OVF_COUNT), .UNF_COUNT(UNF_COUNT), .POP_COUNT(POP_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [AW-1:0] ra;
        logic          empty;
        logic          full;
        logic [31:0]   ovf;
        logic [31:0]   unf;
        logic [31:0]   pops;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [AW-1:0] model[$];
    int unsigned   ovf = 0, unf = 0, pops = 0;
    int            checks = 0, failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t predict();
        exp_t e;
        e.ra    = model.size() != 0 ? model[model.size()-1] : '0;
        e.empty = model.size() == 0;
        e.full  = model.size() == D;
        e.ovf   = ovf;
        e.unf   = unf;
        e.pops  = pops;
        return e;
    endfunction

    task automatic compare(input string tag, input exp_t e);
        check({tag, ".return_addr"}, 64'(RETURN_ADDR), 64'(e.ra));
        check({tag, ".empty"}, 64'(EMPTY), 64'(e.empty));
        check({tag, ".full"}, 64'(FULL), 64'(e.full));
`ifdef RAS_STATS_EN
        check({tag, ".ovf_count"}, 64'(OVF_COUNT), 64'(e.ovf));
        check({tag, ".unf_count"}, 64'(UNF_COUNT), 64'(e.unf));
        check({tag, ".pop_count"}, 64'(POP_COUNT), 64'(e.pops));
`endif
    endtask

    // issue one cycle of stimulus at a negedge and queue the state expected after the next edge
    task automatic step(input logic push, input logic pop, input logic [AW-1:0] addr,
                        input logic cr = 1, input logic crd = 1, input logic fl = 0);
        PUSH = push; POP = pop; PUSH_ADDR = addr;
        CACHE_READY = cr; CACHE_READY_DATA = crd; FLUSH = fl;
        if (cr && crd && !fl) begin
            if (push && pop && model.size() != 0) begin
                model[model.size()-1] = addr;
            end else if (push) begin
                if (model.size() == D) begin
                    void'(model.pop_front());
                    if (!pop) ovf++;
                end
                model.push_back(addr);
            end else if (pop) begin
                if (model.size() != 0) void'(model.pop_back());
                else unf++;
            end
            if (pop) pops++;
        end
        sb.push_back(predict());
        @(negedge CLK);
    endtask

    task automatic quiet();
        PUSH = 0; POP = 0;
    endtask

    task automatic clear_model();
        model.delete();
        ovf = 0; unf = 0; pops = 0;
    endtask

    initial forever begin
        @(posedge CLK);
        #1;
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            compare("mon", mon_e);
        end
    end

    initial begin
        repeat (2) @(negedge CLK);
        compare("reset", predict());
        RSTN = 1;
        @(negedge CLK);
        step(1, 0, 'h100); step(1, 0, 'h200); step(1, 0, 'h300);
        repeat (4) step(0, 1, '0);
        for (int i = 1; i <= 9; i++) step(1, 0, AW'(i * 'h10));
        repeat (8) step(0, 1, '0);
        step(1, 0, 'h400);
        step(1, 1, 'h500);
        step(0, 1, '0);
        step(1, 1, 'h550);
        step(1, 0, 'h600, 1, 0, 0);
        step(1, 0, 'h700, 1, 1, 1);
        step(1, 1, 'h780, 0, 1, 0);
        step(0, 1, '0, 1, 1, 1);
        step(1, 0, 'hA0);
        step(1, 0, 'hB0);
        quiet();
        #2 RSTN = 0;
        #1;
        clear_model();
        compare("async_reset", predict());
        @(negedge CLK);
        RSTN = 1;
        @(negedge CLK);
        for (int i = 0; i < 600; i++) begin
            logic          p, q, cr, crd, fl;
            logic [AW-1:0] a;
            p   = $urandom_range(0, 9) < 5;
            q   = $urandom_range(0, 9) < 4;
            cr  = $urandom_range(0, 9) != 0;
            crd = $urandom_range(0, 9) != 0;
            fl  = $urandom_range(0, 15) == 0;
            a   = AW'($urandom) & ~AW'(3);
            step(p, q, a, cr, crd, fl);
        end
        quiet();
        repeat (3) @(negedge CLK);
        check("scoreboard_drained", 64'(sb.size()), 64'(0));
        compare("final", predict());
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
